counter_updown_mod_nbit: RTL and testbench
==========================================

Name: counter_updown_mod_nbit

Overview:
- Parametrised up/down counter for timers, address generators and channel sequencers; next generation of the team's loadable up/down counter.
- Adds a count enable, a programmable step and a programmable modulus (terminal value).
- Adds a wrap or saturate mode, a registered terminal-count pulse, and sticky overflow/underflow flags.

Parameters:
CNT_WIDTH, 8, counter width in bits
STEP_WIDTH, 4, width of the step input
PRESCALE_WIDTH, 4, prescaler divider width (used only with COUNTER_PRESCALE_EN)

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
en  input  1  count enable
load_en  input  1  load counter_in
counter_in  input  CNT_WIDTH  load value
up_down  input  1  1 = count up, 0 = count down
step  input  STEP_WIDTH  increment/decrement amount
max_val  input  CNT_WIDTH  terminal value; counting range is 0..max_val inclusive
sat_mode  input  1  1 = saturate at bounds, 0 = wrap modulo (max_val+1)
flag_clr  input  1  clears ovf_flag and udf_flag
counter_out  output reg  CNT_WIDTH  count value
tc  output reg  1  one-cycle terminal-count pulse
ovf_flag  output reg  1  sticky up-boundary event
udf_flag  output reg  1  sticky down-boundary event
at_max  output  1  combinational: counter_out == max_val
at_zero  output  1  combinational: counter_out == 0

Behaviour:
- Single clock domain, clk. Reset is synchronous and active-high.
- Reset: counter_out=0, tc=0, ovf_flag=0, udf_flag=0, prescaler state=0.
- Priority: reset > load_en > step (en).
- All state is registered. A step is visible on counter_out one cycle after the enabled edge; tc and the flags update on the same edge.
- tc is 0 on every cycle that is not a boundary event.
- Load: counter_out <= (counter_in > max_val) ? max_val : counter_in. No tc, no flag change.
- Effective step: s = min(step, max_val+1), computed in CNT_WIDTH+1 bits. max_val+1 must not truncate.
- step == 0 with en: counter holds, no boundary event.
- Up step, n = counter_out + s (CNT_WIDTH+1 bits):
  - n <= max_val: counter_out <= n.
  - n > max_val: boundary event. Wrap mode: counter_out <= n - (max_val+1). Saturate mode: counter_out <= max_val.
- Down step:
  - s <= counter_out: counter_out <= counter_out - s.
  - Otherwise boundary event. Wrap mode: counter_out <= counter_out + (max_val+1) - s. Saturate mode: counter_out <= 0.
- Saturate mode: an enabled up step at max_val (or down step at 0) with s > 0 is a boundary event. Counter holds, tc pulses, flag sets.
- Boundary event: tc <= 1 for that cycle. Up sets ovf_flag; down sets udf_flag.
- Flags: flag_clr clears both. A set in the same cycle as flag_clr wins.
- Out-of-range count (max_val lowered so counter_out > max_val) on an enabled step: counter_out <= up_down ? 0 : max_val. No tc, no flag.
- max_val == 0: counter stays 0. Every enabled step with step != 0 is a boundary event.
- Reset mid-count overrides load/en in the same cycle.

Optional Feature:
COUNTER_PRESCALE_EN
- Defined:
  - Adds input presc_div [PRESCALE_WIDTH-1:0] and an internal prescaler counter.
  - The prescaler increments on each en cycle that is not a load.
  - A counter step occurs only on an en cycle where the prescaler == presc_div; the prescaler then returns to 0.
  - load_en and reset clear the prescaler.
  - presc_div == 0 gives a step on every en cycle.
- Not defined: no presc_div port, no prescaler logic; every en cycle steps.

Test Plan:
- Reset, then CNT_WIDTH=8, max_val=9, step=1, up, wrap, en=1 for 12 cycles -> counter_out 1..9,0,1,2; tc=1 for exactly the cycle counter_out shows 0; ovf_flag=1 thereafter.
- max_val=9, step=3, down, wrap, load 4 then en x3 -> counter_out 4,1,8,5; tc pulses once (on the 8); udf_flag=1.
- sat_mode=1, max_val=200, load 199, step=5, up, en x3 -> counter_out 200,200,200; tc=1 each cycle; ovf_flag set. Then flag_clr with no event -> ovf_flag=0.
- load_en=1 with en=1, counter_in=250, max_val=100 -> counter_out=100, tc=0. reset=1 with load_en=1 -> counter_out=0.
- counter_out=50, then max_val changed to 20, en up -> counter_out=0, tc=0, flags unchanged. Same case with step=0 -> counter_out=0, no event.
- COUNTER_PRESCALE_EN defined, presc_div=2, step=1, en=1 for 9 cycles from 0 -> counter_out increments on cycles 3, 6, 9 only.

Source files
------------

// File: rtl/counter_updown_mod_nbit.sv
// Up/down modulo counter: enable, programmable step and terminal value,
// wrap/saturate, tc pulse, sticky flags. Optional prescaler: COUNTER_PRESCALE_EN.
module counter_updown_mod_nbit #(
    parameter int CNT_WIDTH      = 8,
    parameter int STEP_WIDTH     = 4,
    parameter int PRESCALE_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  load_en,
    input  logic [CNT_WIDTH-1:0]  counter_in,
    input  logic                  up_down,
    input  logic [STEP_WIDTH-1:0] step,
    input  logic [CNT_WIDTH-1:0]  max_val,
    input  logic                  sat_mode,
    input  logic                  flag_clr,
`ifdef COUNTER_PRESCALE_EN
    input  logic [PRESCALE_WIDTH-1:0] presc_div,
`endif
    output logic [CNT_WIDTH-1:0]  counter_out,
    output logic                  tc,
    output logic                  ovf_flag,
    output logic                  udf_flag,
    output logic                  at_max,
    output logic                  at_zero
);

    localparam int W1 = CNT_WIDTH + 1;
    localparam int SW = (STEP_WIDTH > W1) ? STEP_WIDTH : W1;

    logic [W1-1:0]        modulus;
    logic [W1-1:0]        cnt_x;
    logic [W1-1:0]        max_x;
    logic [W1-1:0]        s;
    logic [W1-1:0]        sum;
    logic [CNT_WIDTH-1:0] nxt;
    logic [CNT_WIDTH-1:0] load_val;
    logic                 evt;
    logic                 tick;
    logic                 step_now;

    assign max_x    = {1'b0, max_val};
    assign cnt_x    = {1'b0, counter_out};
    assign modulus  = max_x + 1'b1;
    // Clamp the step to one full lap so wrap arithmetic stays in range.
    assign s        = (SW'(step) > SW'(modulus)) ? modulus : W1'(step);
    assign sum      = cnt_x + s;
    assign load_val = (counter_in > max_val) ? max_val : counter_in;

    assign at_max  = (counter_out == max_val);
    assign at_zero = (counter_out == '0);

`ifdef COUNTER_PRESCALE_EN
    logic [PRESCALE_WIDTH-1:0] presc;

    assign tick = en && (presc == presc_div);

    always_ff @(posedge clk) begin
        if (reset) begin
            presc <= '0;
        end else if (load_en) begin
            presc <= '0;
        end else if (en) begin
            presc <= (presc == presc_div) ? '0 : presc + 1'b1;
        end
    end
`else
    assign tick = en;
`endif

    always_comb begin
        nxt = counter_out;
        evt = 1'b0;
        if (counter_out > max_val) begin
            nxt = up_down ? '0 : max_val;
        end else if (s == '0) begin
            nxt = counter_out;
        end else if (up_down) begin
            if (sum > max_x) begin
                evt = 1'b1;
                nxt = sat_mode ? max_val : CNT_WIDTH'(sum - modulus);
            end else begin
                nxt = CNT_WIDTH'(sum);
            end
        end else begin
            if (s <= cnt_x) begin
                nxt = CNT_WIDTH'(cnt_x - s);
            end else begin
                evt = 1'b1;
                nxt = sat_mode ? '0 : CNT_WIDTH'(cnt_x + modulus - s);
            end
        end
    end

    assign step_now = tick && !load_en;

    always_ff @(posedge clk) begin
        if (reset) begin
            counter_out <= '0;
            tc          <= 1'b0;
            ovf_flag    <= 1'b0;
            udf_flag    <= 1'b0;
        end else begin
            tc <= 1'b0;
            if (load_en) begin
                counter_out <= load_val;
            end else if (tick) begin
                counter_out <= nxt;
                tc          <= evt;
            end
            // A new event outranks a simultaneous clear.
            if (step_now && evt && up_down) begin
                ovf_flag <= 1'b1;
            end else if (flag_clr) begin
                ovf_flag <= 1'b0;
            end
            if (step_now && evt && !up_down) begin
                udf_flag <= 1'b1;
            end else if (flag_clr) begin
                udf_flag <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_counter_updown_mod_nbit.sv
// Scoreboard bench for counter_updown_mod_nbit: driver queues expected
// state per cycle, a negedge monitor pops and compares.
module tb_counter_updown_mod_nbit;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       en = 1'b0;
    logic       load_en = 1'b0;
    logic [7:0] counter_in = '0;
    logic       up_down = 1'b1;
    logic [3:0] step = '0;
    logic [7:0] max_val = 8'd9;
    logic       sat_mode = 1'b0;
    logic       flag_clr = 1'b0;
`ifdef COUNTER_PRESCALE_EN
    logic [3:0] presc_div = '0;
`endif
    logic [7:0] counter_out;
    logic       tc, ovf_flag, udf_flag, at_max, at_zero;

    typedef struct {
        int         id;
        logic [7:0] cnt;
        logic       tc;
        logic       ovf;
        logic       udf;
        logic       amax;
        logic       azero;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;
    int   vec = 0;

    always #5 clk = ~clk;

    counter_updown_mod_nbit #(
        .CNT_WIDTH(8),
        .STEP_WIDTH(4),
        .PRESCALE_WIDTH(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .en(en),
        .load_en(load_en),
        .counter_in(counter_in),
        .up_down(up_down),
        .step(step),
        .max_val(max_val),
        .sat_mode(sat_mode),
        .flag_clr(flag_clr),
`ifdef COUNTER_PRESCALE_EN
        .presc_div(presc_div),
`endif
        .counter_out(counter_out),
        .tc(tc),
        .ovf_flag(ovf_flag),
        .udf_flag(udf_flag),
        .at_max(at_max),
        .at_zero(at_zero)
    );

    task automatic cyc(
        input logic r, input logic e, input logic l, input logic [7:0] ci,
        input logic ud, input logic [3:0] st, input logic [7:0] mx,
        input logic sm, input logic cl,
        input logic [7:0] ec, input logic et, input logic eo, input logic eu
    );
        exp_t x;
        @(negedge clk);
        #1;
        reset = r; en = e; load_en = l; counter_in = ci;
        up_down = ud; step = st; max_val = mx; sat_mode = sm; flag_clr = cl;
        @(posedge clk);
        #1;
        x.id = vec; x.cnt = ec; x.tc = et; x.ovf = eo; x.udf = eu;
        x.amax = (ec == mx); x.azero = (ec == 8'd0);
        q.push_back(x);
        vec++;
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t x;
            x = q.pop_front();
            tests++;
            if (counter_out !== x.cnt || tc !== x.tc || ovf_flag !== x.ovf ||
                udf_flag !== x.udf || at_max !== x.amax || at_zero !== x.azero) begin
                fails++;
                $display("FAIL vec%0d: got cnt=%0d tc=%b ovf=%b udf=%b max=%b zero=%b want cnt=%0d tc=%b ovf=%b udf=%b max=%b zero=%b",
                         x.id, counter_out, tc, ovf_flag, udf_flag, at_max, at_zero,
                         x.cnt, x.tc, x.ovf, x.udf, x.amax, x.azero);
            end
        end
    end

    initial begin
        // reset state
        cyc(1,0,0,0,  1,1,9,0,0,  0,0,0,0);
        // up wrap, max 9, step 1: 1..9,0,1,2
        for (int i = 1; i <= 12; i++)
            cyc(0,1,0,0, 1,1,9,0,0, 8'(i % 10), i == 10, i >= 10, 0);
        // down wrap step 3 from 4: 4,1,8,5
        cyc(0,0,1,4,  0,3,9,0,1,  4,0,0,0);
        cyc(0,1,0,0,  0,3,9,0,0,  1,0,0,0);
        cyc(0,1,0,0,  0,3,9,0,0,  8,1,0,1);
        cyc(0,1,0,0,  0,3,9,0,0,  5,0,0,1);
        // saturate up at 200
        cyc(0,0,1,199,1,5,200,1,1, 199,0,0,0);
        cyc(0,1,0,0,  1,5,200,1,0, 200,1,1,0);
        cyc(0,1,0,0,  1,5,200,1,0, 200,1,1,0);
        cyc(0,1,0,0,  1,5,200,1,0, 200,1,1,0);
        cyc(0,0,0,0,  1,5,200,1,1, 200,0,0,0);
        // event beats a simultaneous clear
        cyc(0,1,0,0,  1,5,200,1,1, 200,1,1,0);
        // load clamps and beats en; reset beats load
        cyc(0,1,1,250,1,1,100,0,0, 100,0,1,0);
        cyc(1,1,1,250,1,1,100,0,0, 0,0,0,0);
        // out of range after lowering max_val
        cyc(0,0,1,50, 1,1,100,0,0, 50,0,0,0);
        cyc(0,1,0,0,  1,1,20,0,0,  0,0,0,0);
        cyc(0,0,1,50, 1,0,100,0,0, 50,0,0,0);
        cyc(0,1,0,0,  1,0,20,0,0,  0,0,0,0);
        cyc(0,0,1,50, 0,1,100,0,0, 50,0,0,0);
        cyc(0,1,0,0,  0,1,20,0,0,  20,0,0,0);
        // step 0 holds, en 0 holds
        cyc(0,1,0,0,  0,0,20,0,0,  20,0,0,0);
        cyc(0,0,0,0,  1,3,20,0,0,  20,0,0,0);
        // max_val 0
        cyc(0,1,0,0,  1,5,0,0,0,   0,0,0,0);
        cyc(0,1,0,0,  1,5,0,0,0,   0,1,1,0);
        cyc(0,1,0,0,  0,5,0,0,0,   0,1,1,1);
        // step larger than the lap is clamped to max_val+1
        cyc(0,0,1,3,  1,15,9,0,1,  3,0,0,0);
        cyc(0,1,0,0,  1,15,9,0,0,  3,1,1,0);
        cyc(0,1,0,0,  0,15,9,0,0,  3,1,1,1);
        // full-width modulus 256
        cyc(0,0,1,250,1,8,255,0,1, 250,0,0,0);
        cyc(0,1,0,0,  1,8,255,0,0, 2,1,1,0);
        cyc(0,1,0,0,  0,5,255,0,0, 253,1,1,1);
        cyc(0,1,0,0,  0,15,255,1,1, 238,0,0,0);
        // saturate down to 0
        cyc(0,0,1,4,  0,7,9,1,0,   4,0,0,0);
        cyc(0,1,0,0,  0,7,9,1,0,   0,1,0,1);
        cyc(0,1,0,0,  0,7,9,1,0,   0,1,0,1);
`ifdef COUNTER_PRESCALE_EN
        // prescaler: steps land on en cycles 3, 6, 9
        cyc(0,0,1,0,  1,1,9,0,1,   0,0,0,0);
        presc_div = 4'd2;
        for (int i = 1; i <= 9; i++)
            cyc(0,1,0,0, 1,1,9,0,0, 8'(i / 3), 0, 0, 0);
        presc_div = 4'd0;
`endif
        for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge clk);
        #1;
        if (q.size() > 0) begin
            tests++;
            fails++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
